// File: rtl/vga_scanout.sv
// vga_scanout: VGA raster timing generator and registered pin driver.
// Pops one 24-bit pixel per active cycle; pulses next_frame once per frame.
//
// Ports:
//   clk, reset          pixel clock, async active-high reset
//   st_pixel_data       {R,G,B} pixel from the pixel reader
//   st_pixel_valid      upstream has a pixel
//   st_pixel_ready      high in the active region (counters only)
//   next_frame          one-cycle pulse, upstream restarts its frame
//   vga_r/g/b           registered colour, black outside vga_de
//   vga_hsync/vsync     registered active-low syncs
//   vga_de              registered data enable
//   underflow           sticky flag (VGA_SCANOUT_UNDERFLOW_EN only)
//   clear_underflow     synchronous clear for underflow
//
// Build option: define VGA_SCANOUT_UNDERFLOW_EN to enable the sticky
// underflow flag; otherwise underflow is tied to 0.

module vga_scanout #(
   parameter int H_ACTIVE = 640,
   parameter int H_FRONT  = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BACK   = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FRONT  = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BACK   = 33
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [23:0] st_pixel_data,
   input  logic        st_pixel_valid,
   output logic        st_pixel_ready,
   output logic        next_frame,
   output logic [7:0]  vga_r,
   output logic [7:0]  vga_g,
   output logic [7:0]  vga_b,
   output logic        vga_hsync,
   output logic        vga_vsync,
   output logic        vga_de,
   output logic        underflow,
   input  logic        clear_underflow
);

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
   localparam int HW = $clog2(H_TOTAL);
   localparam int VW = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FRONT);
   localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FRONT + H_SYNC);

   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FRONT);
   localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FRONT + V_SYNC);

   logic [HW-1:0] h;
   logic [VW-1:0] v;
   logic          active;
   logic          hs_on;
   logic          vs_on;
   logic          take;
   logic          starving;

   // Counters start at the top of vertical blanking so the upstream
   // gets a whole blanking interval to prefetch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h <= '0;
         v <= V_ACT;
      end else if (h == H_LAST) begin
         h <= '0;
         v <= (v == V_LAST) ? '0 : v + 1'b1;
      end else begin
         h <= h + 1'b1;
      end
   end

   assign active   = (h < H_ACT) && (v < V_ACT);
   assign hs_on    = (h >= HS_BEG) && (h < HS_END);
   assign vs_on    = (v >= VS_BEG) && (v < VS_END);
   assign take     = active & st_pixel_valid;
   assign starving = active & ~st_pixel_valid;

   assign st_pixel_ready = active;

   // Everything goes through one register stage so colour, syncs and
   // data enable stay aligned. A starved active cycle shows black.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vga_r      <= '0;
         vga_g      <= '0;
         vga_b      <= '0;
         vga_hsync  <= 1'b1;
         vga_vsync  <= 1'b1;
         vga_de     <= 1'b0;
         next_frame <= 1'b0;
      end else begin
         {vga_r, vga_g, vga_b} <= take ? st_pixel_data : 24'h0;
         vga_hsync  <= ~hs_on;
         vga_vsync  <= ~vs_on;
         vga_de     <= active;
         next_frame <= (h == '0) && (v == V_ACT);
      end
   end

`ifdef VGA_SCANOUT_UNDERFLOW_EN
   // A new underflow takes priority over a simultaneous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         underflow <= 1'b0;
      end else if (starving) begin
         underflow <= 1'b1;
      end else if (clear_underflow) begin
         underflow <= 1'b0;
      end
   end
`else
   logic unused_uf;
   assign unused_uf = clear_underflow ^ starving;
   assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: directed scoreboard bench for vga_scanout,
// small raster H=4/1/1/1, V=2/1/1/1.

module tb_vga_scanout;

   localparam int HA = 4, HF = 1, HS = 1, HB = 1;
   localparam int VA = 2, VF = 1, VS = 1, VB = 1;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;

`ifdef VGA_SCANOUT_UNDERFLOW_EN
   localparam logic UF_ON = 1'b1;
`else
   localparam logic UF_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [23:0] st_pixel_data;
   logic        st_pixel_valid;
   logic        st_pixel_ready;
   logic        next_frame;
   logic [7:0]  vga_r, vga_g, vga_b;
   logic        vga_hsync, vga_vsync, vga_de;
   logic        underflow;
   logic        clear_underflow;

   always #5 clk = ~clk;

   vga_scanout #(
      .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
   ) dut (
      .clk(clk),
      .reset(reset),
      .st_pixel_data(st_pixel_data),
      .st_pixel_valid(st_pixel_valid),
      .st_pixel_ready(st_pixel_ready),
      .next_frame(next_frame),
      .vga_r(vga_r),
      .vga_g(vga_g),
      .vga_b(vga_b),
      .vga_hsync(vga_hsync),
      .vga_vsync(vga_vsync),
      .vga_de(vga_de),
      .underflow(underflow),
      .clear_underflow(clear_underflow)
   );

   typedef struct packed {
      logic [23:0] rgb;
      logic        de;
      logic        hs;
      logic        vs;
      logic        nf;
      logic        uf;
   } pins_t;

   pins_t       sb[$];
   int          checks = 0;
   int          errors = 0;
   logic        m_uf;
   int          beat;
   logic [23:0] beats [0:7];
   logic [23:0] obs_rgb [0:63];
   logic        obs_de  [0:63];
   logic        obs_vs  [0:63];
   logic        obs_nf  [0:63];
   logic        obs_uf  [0:63];
   logic        obs_rdy [0:63];

   function automatic pins_t reset_pins();
      pins_t p;
      p.rgb = 24'h0;
      p.de  = 1'b0;
      p.hs  = 1'b1;
      p.vs  = 1'b1;
      p.nf  = 1'b0;
      p.uf  = 1'b0;
      return p;
   endfunction

   function automatic pins_t cur_pins();
      pins_t p;
      p = {vga_r, vga_g, vga_b, vga_de, vga_hsync,
           vga_vsync, next_frame, underflow};
      return p;
   endfunction

   task automatic chk_pins(input string tag, input pins_t exp);
      pins_t obs;
      obs = cur_pins();
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_rgb(input string tag, input logic [23:0] obs,
                          input logic [23:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic start_model();
      sb.delete();
      m_uf = 1'b0;
      beat = 0;
      sb.push_back(reset_pins());
   endtask

   task automatic do_reset();
      reset           = 1'b1;
      st_pixel_valid  = 1'b0;
      st_pixel_data   = 24'h0;
      clear_underflow = 1'b0;
      @(posedge clk);
      #1;
      chk_pins("reset_pins", reset_pins());
      chk_bit("reset_ready", st_pixel_ready, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      start_model();
   endtask

   // mode 0: no stimulus; mode 1: valid high except at bad_k
   task automatic run(input int n, input int mode, input int bad_k,
                      input int clr_k);
      for (int k = 0; k < n; k++) begin
         int    h, v;
         logic  act, vld, clr;
         pins_t e;
         h   = k % HT;
         v   = (VA + k / HT) % VT;
         act = (h < HA) && (v < VA);
         vld = (mode != 0) && (k != bad_k);
         clr = (k == clr_k);
         st_pixel_valid  = vld;
         st_pixel_data   = beats[beat % 8];
         clear_underflow = clr;
         e = sb.pop_front();
         chk_pins($sformatf("pins k=%0d", k), e);
         chk_bit($sformatf("ready k=%0d", k), st_pixel_ready, act);
         if (k < 64) begin
            obs_rgb[k] = {vga_r, vga_g, vga_b};
            obs_de[k]  = vga_de;
            obs_vs[k]  = vga_vsync;
            obs_nf[k]  = next_frame;
            obs_uf[k]  = underflow;
            obs_rdy[k] = st_pixel_ready;
         end
         e.rgb = (act && vld) ? st_pixel_data : 24'h0;
         e.de  = act;
         e.hs  = !((h >= HA + HF) && (h < HA + HF + HS));
         e.vs  = !((v >= VA + VF) && (v < VA + VF + VS));
         e.nf  = (h == 0) && (v == VA);
         if (UF_ON && act && !vld) m_uf = 1'b1;
         else if (clr)             m_uf = 1'b0;
         e.uf = m_uf & UF_ON;
         sb.push_back(e);
         if (act && vld) beat++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_idle_frame(input string tag);
      int pulses;
      pulses = 0;
      for (int k = 0; k < 40; k++) pulses += int'(obs_nf[k]);
      chk_int({tag, "_nf_count"}, pulses, 2);
      chk_bit({tag, "_nf1"}, obs_nf[1], 1'b1);
      chk_bit({tag, "_nf36"}, obs_nf[36], 1'b1);
      chk_bit({tag, "_vs7"}, obs_vs[7], 1'b1);
      chk_bit({tag, "_vs8"}, obs_vs[8], 1'b0);
      chk_bit({tag, "_vs14"}, obs_vs[14], 1'b0);
      chk_bit({tag, "_vs15"}, obs_vs[15], 1'b1);
   endtask

   initial begin
      beats[0] = 24'h0000FF;
      beats[1] = 24'h00FF00;
      beats[2] = 24'hFF0000;
      beats[3] = 24'h123456;
      beats[4] = 24'hA5A5A5;
      beats[5] = 24'h5A5A5A;
      beats[6] = 24'h010203;
      beats[7] = 24'hFEDCBA;

      // idle frame after reset
      do_reset();
      run(40, 0, -1, -1);
      check_idle_frame("idle");
      chk_bit("rdy20", obs_rdy[20], 1'b0);
      chk_bit("rdy21", obs_rdy[21], 1'b1);
      chk_bit("rdy24", obs_rdy[24], 1'b1);
      chk_bit("rdy25", obs_rdy[25], 1'b0);
      chk_bit("rdy28", obs_rdy[28], 1'b1);
      chk_bit("rdy31", obs_rdy[31], 1'b1);
      chk_bit("rdy32", obs_rdy[32], 1'b0);

      // valid held high, pixel ordering on the pins
      do_reset();
      run(30, 1, -1, -1);
      chk_rgb("px22", obs_rgb[22], 24'h0000FF);
      chk_rgb("px23", obs_rgb[23], 24'h00FF00);
      chk_rgb("px24", obs_rgb[24], 24'hFF0000);
      chk_rgb("px25", obs_rgb[25], 24'h123456);
      chk_rgb("px26", obs_rgb[26], 24'h000000);
      chk_bit("de21", obs_de[21], 1'b0);
      chk_bit("de22", obs_de[22], 1'b1);
      chk_bit("de25", obs_de[25], 1'b1);
      chk_bit("de26", obs_de[26], 1'b0);

      // one starved cycle, later cleared
      do_reset();
      run(30, 1, 23, 27);
      chk_rgb("uf_px24", obs_rgb[24], 24'h000000);
      chk_rgb("uf_px25", obs_rgb[25], 24'hFF0000);
      chk_bit("uf23", obs_uf[23], 1'b0);
      chk_bit("uf24", obs_uf[24], UF_ON);
      chk_bit("uf27", obs_uf[27], UF_ON);
      chk_bit("uf28", obs_uf[28], 1'b0);

      // starve and clear together: set wins
      do_reset();
      run(26, 1, 23, 23);
      chk_bit("ufclr24", obs_uf[24], UF_ON);
      chk_bit("ufclr25", obs_uf[25], UF_ON);

      // asynchronous reset mid-frame
      do_reset();
      run(23, 1, -1, -1);
      chk_bit("pre_rst_de", vga_de, 1'b1);
      chk_rgb("pre_rst_rgb", {vga_r, vga_g, vga_b}, 24'h00FF00);
      #3;
      reset = 1'b1;
      #1;
      chk_pins("async_rst_pins", reset_pins());
      chk_bit("async_rst_ready", st_pixel_ready, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      chk_pins("held_rst_pins", reset_pins());
      reset = 1'b0;
      st_pixel_valid = 1'b0;
      start_model();
      run(40, 0, -1, -1);
      check_idle_frame("rerun");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
